// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Memory-stage access controller. It sequences one load, store, LL or SC per
// instruction against the data cache and holds the pipeline with mem_stall
// until the cache answers. It owns the LL/SC link register, including
// coherence-snoop invalidation, and presents a registered result for MEM/WB.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic              req_ll,
    input  logic              req_sc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_wdata,
    input  logic              dhit,
    input  logic [ADDR_W-1:0] dmemload,
    input  logic              inv_valid,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [ADDR_W-1:0] dmemstore,
    output logic [ADDR_W-1:0] wb_data,
    output logic              mem_stall,
    output logic              mem_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic              link_valid_reg;
    logic              link_valid_next;
    logic [ADDR_W-1:0] link_addr_reg;
    logic [ADDR_W-1:0] link_addr_next;
    logic [ADDR_W-1:0] wb_data_reg;
    logic [ADDR_W-1:0] wb_data_next;

    // Request decode. A read wins if both enables are ever raised together.
    logic req;
    logic is_load;
    logic is_store;
    logic is_ll;
    logic is_sc;
    logic is_plain_sw;

    // Link / access status for the current cycle.
    logic link_hit;
    logic inv_hit;
    logic in_access_state;
    logic sc_blocked;
    logic access_live;
    logic access_done;
    logic sc_finish;
    logic sc_result;

    // Only the word index of the link and snoop addresses is compared.
    logic unused_bits;

    assign req         = req_ren | req_wen;
    assign is_load     = req_ren;
    assign is_store    = req_wen & ~req_ren;
    assign is_ll       = is_load & req_ll;
    assign is_sc       = is_store & req_sc;
    assign is_plain_sw = is_store & ~req_sc;

    assign link_hit = link_valid_reg &
                      (link_addr_reg[ADDR_W-1:2] == req_addr[ADDR_W-1:2]);
    assign inv_hit  = inv_valid &
                      (inv_addr[ADDR_W-1:2] == link_addr_reg[ADDR_W-1:2]);

    assign in_access_state = (state_reg == IDLE) | (state_reg == WAIT);

    // An SC whose link is gone never touches the cache; it just fails.
    assign sc_blocked  = is_sc & ~link_hit;

    // A cache access is in flight only while enables are driven, so a dhit
    // seen in DONE, in an empty IDLE or on a blocked SC is ignored.
    assign access_live = in_access_state & req & ~sc_blocked;
    assign access_done = access_live & dhit;

    // The SC result is decided on the cycle the FSM moves into DONE.
    assign sc_finish   = in_access_state & is_sc & (state_next == DONE);
    assign sc_result   = access_done & is_sc;

    assign unused_bits = ^{inv_addr[1:0], link_addr_reg[1:0]};

    // State register; reset forces IDLE immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: issue in IDLE, hold in WAIT, single DONE cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (sc_blocked || dhit) begin
                        state_next = DONE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (sc_blocked || dhit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: enables and stall follow the request combinationally.
    always_comb begin
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_stall = 1'b0;
        mem_done  = 1'b0;
        case (state_reg)
            IDLE, WAIT: begin
                dmemREN   = is_load;
                dmemWEN   = is_store & (~req_sc | link_hit);
                mem_stall = req;
            end
            DONE: begin
                mem_done = 1'b1;
            end
            default: begin
                mem_done = 1'b0;
            end
        endcase
    end

    assign dmemaddr  = req_addr;
    assign dmemstore = req_wdata;
    assign wb_data   = wb_data_reg;

    // Link register next value; an LL setting the link overrides a snoop
    // clearing it in the same cycle because the LL is the newer link.
    always_comb begin
        link_valid_next = link_valid_reg;
        link_addr_next  = link_addr_reg;
        if (inv_hit) begin
            link_valid_next = 1'b0;
        end
        if (sc_finish) begin
            link_valid_next = 1'b0;
        end
        if (access_done && is_plain_sw && link_hit) begin
            link_valid_next = 1'b0;
        end
        if (access_done && is_ll) begin
            link_valid_next = 1'b1;
            link_addr_next  = req_addr;
        end
    end

    // Write-back data next value: load data on hit, SC flag on completion,
    // plain stores leave it alone.
    always_comb begin
        wb_data_next = wb_data_reg;
        if (access_done && is_load) begin
            wb_data_next = dmemload;
        end else if (sc_finish) begin
            wb_data_next = {{(ADDR_W-1){1'b0}}, sc_result};
        end
    end

    // Link and write-back registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_reg <= 1'b0;
            link_addr_reg  <= '0;
            wb_data_reg    <= '0;
        end else begin
            link_valid_reg <= link_valid_next;
            link_addr_reg  <= link_addr_next;
            wb_data_reg    <= wb_data_next;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Scoreboard bench: the driver computes each transaction's outcome from a
// transaction-level model of the link/result rules and queues it; a monitor
// counts stall/enable cycles and compares when mem_done appears.
module tb_mem_access_ctrl;

    localparam int K_LW = 0;
    localparam int K_SW = 1;
    localparam int K_LL = 2;
    localparam int K_SC = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req_ren;
    logic        req_wen;
    logic        req_ll;
    logic        req_sc;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        dhit;
    logic [31:0] dmemload;
    logic        inv_valid;
    logic [31:0] inv_addr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] wb_data;
    logic        mem_stall;
    logic        mem_done;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_ll    (req_ll),
        .req_sc    (req_sc),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .inv_valid (inv_valid),
        .inv_addr  (inv_addr),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .wb_data   (wb_data),
        .mem_stall (mem_stall),
        .mem_done  (mem_done)
    );

    typedef struct {
        logic [31:0] wb;
        int          stall;
        int          wr;
        int          rd;
    } exp_t;

    exp_t sb_q[$];

    int n_total = 0;
    int n_pass  = 0;

    // Probe requests from the driver, evaluated by the monitor.
    bit          probe_on = 1'b0;
    logic [31:0] probe_wb;
    logic        probe_ren;
    logic        probe_wen;
    logic        probe_stall;
    bit          final_on = 1'b0;

    // Reference model state.
    logic        m_lv;
    logic [31:0] m_la;
    logic [31:0] m_wb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts per-transaction activity and scores on mem_done.
    initial begin
        int cnt_stall;
        int cnt_wr;
        int cnt_rd;
        bit pt_bad;
        exp_t e;
        cnt_stall = 0;
        cnt_wr    = 0;
        cnt_rd    = 0;
        pt_bad    = 1'b0;
        forever begin
            @(negedge CLK);
            if (probe_on) begin
                check("probe_wb_data", wb_data, probe_wb);
                check("probe_dmemREN", 32'(dmemREN), 32'(probe_ren));
                check("probe_dmemWEN", 32'(dmemWEN), 32'(probe_wen));
                check("probe_mem_stall", 32'(mem_stall), 32'(probe_stall));
                check("probe_mem_done", 32'(mem_done), 32'd0);
            end
            if (final_on) begin
                check("queue_drained", 32'(sb_q.size()), 32'd0);
            end
            if (!nRST) begin
                cnt_stall = 0;
                cnt_wr    = 0;
                cnt_rd    = 0;
                pt_bad    = 1'b0;
            end else begin
                if (mem_stall) cnt_stall++;
                if (dmemWEN) cnt_wr++;
                if (dmemREN) cnt_rd++;
                if ((dmemREN || dmemWEN) &&
                    ((dmemaddr !== req_addr) || (dmemstore !== req_wdata))) begin
                    pt_bad = 1'b1;
                end
                if (mem_done) begin
                    if (sb_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_done: mem_done=1 with no transaction outstanding, required 0");
                    end else begin
                        e = sb_q.pop_front();
                        check("wb_data", wb_data, e.wb);
                        check("stall_cycles", 32'(cnt_stall), 32'(e.stall));
                        check("wen_cycles", 32'(cnt_wr), 32'(e.wr));
                        check("ren_cycles", 32'(cnt_rd), 32'(e.rd));
                        check("addr_data_passthrough", 32'(pt_bad), 32'd0);
                    end
                    $display("txn done: wb_data=0x%08h stall=%0d wen=%0d ren=%0d",
                             wb_data, cnt_stall, cnt_wr, cnt_rd);
                    cnt_stall = 0;
                    cnt_wr    = 0;
                    cnt_rd    = 0;
                    pt_bad    = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic probe(input logic [31:0] wb, input logic ren, input logic wen, input logic stall);
        probe_wb    = wb;
        probe_ren   = ren;
        probe_wen   = wen;
        probe_stall = stall;
        probe_on    = 1'b1;
        @(negedge CLK);
        #1;
        probe_on = 1'b0;
    endtask

    task automatic clear_req();
        req_ren = 1'b0;
        req_wen = 1'b0;
        req_ll  = 1'b0;
        req_sc  = 1'b0;
    endtask

    // Idle cycles with no request; optional snoop in the first one and
    // random stray dhit strobes that must be ignored.
    task automatic do_idle(input int cycles, input bit inv_on, input logic [31:0] ia);
        for (int c = 0; c < cycles; c++) begin
            clear_req();
            dhit      = 1'($urandom_range(0, 1));
            dmemload  = $urandom;
            inv_valid = inv_on && (c == 0);
            inv_addr  = inv_valid ? ia : $urandom;
            if (inv_valid && m_lv && (ia[31:2] == m_la[31:2])) m_lv = 1'b0;
            step();
        end
    endtask

    // One memory instruction: n = cycles before dhit, ic = cycle of a snoop
    // within the instruction (-1 for none).
    task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                         input int n, input int ic, input logic [31:0] ia,
                         input logic [31:0] data);
        exp_t e;
        bit   hit0;
        bit   inv_m;
        int   stall;
        hit0  = m_lv && (m_la[31:2] == addr[31:2]);
        inv_m = (ic >= 0) && m_lv && (ia[31:2] == m_la[31:2]);
        e.rd  = 0;
        e.wr  = 0;
        case (kind)
            K_LW, K_LL: begin
                stall = n + 1;
                e.rd  = n + 1;
                e.wb  = data;
            end
            K_SW: begin
                stall = n + 1;
                e.wr  = n + 1;
                e.wb  = m_wb;
            end
            default: begin
                if (!hit0) begin
                    stall = 1;
                    e.wb  = 32'd0;
                end else if (inv_m && (ic < n)) begin
                    stall = ic + 2;
                    e.wr  = ic + 1;
                    e.wb  = 32'd0;
                end else begin
                    stall = n + 1;
                    e.wr  = n + 1;
                    e.wb  = 32'd1;
                end
            end
        endcase
        e.stall = stall;
        case (kind)
            K_LL: begin
                m_lv = !((ic == stall) && (ia[31:2] == addr[31:2]));
                m_la = addr;
            end
            K_SC: m_lv = 1'b0;
            K_SW: if (hit0 || inv_m) m_lv = 1'b0;
            default: if (inv_m) m_lv = 1'b0;
        endcase
        m_wb = e.wb;
        sb_q.push_back(e);
        for (int c = 0; c <= stall; c++) begin
            req_ren   = (kind == K_LW) || (kind == K_LL);
            req_wen   = (kind == K_SW) || (kind == K_SC);
            req_ll    = (kind == K_LL);
            req_sc    = (kind == K_SC);
            req_addr  = addr;
            req_wdata = wdata;
            if (c == n) begin
                dhit     = 1'b1;
                dmemload = data;
            end else if (c == stall) begin
                dhit     = 1'($urandom_range(0, 1));
                dmemload = $urandom;
            end else begin
                dhit     = 1'b0;
                dmemload = $urandom;
            end
            inv_valid = (c == ic);
            inv_addr  = (c == ic) ? ia : $urandom;
            step();
        end
    endtask

    initial begin
        logic [31:0] bases [4];
        int          kind;
        int          n;
        int          ic;
        logic [31:0] addr;
        logic [31:0] ia;
        bases[0] = 32'h100;
        bases[1] = 32'h200;
        bases[2] = 32'h204;
        bases[3] = 32'h300;

        nRST      = 1'b0;
        clear_req();
        req_addr  = 32'h40;
        req_wdata = 32'h0;
        dhit      = 1'b0;
        dmemload  = 32'h0;
        inv_valid = 1'b0;
        inv_addr  = 32'h0;
        m_lv      = 1'b0;
        m_la      = 32'h0;
        m_wb      = 32'h0;

        // In reset the enables still follow the request.
        req_ren = 1'b1;
        probe(32'h0, 1'b1, 1'b0, 1'b1);
        req_ren = 1'b0;
        probe(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        nRST = 1'b1;

        // Directed cases.
        do_op(K_LW, 32'h100, 32'h0, 3, -1, 32'h0, 32'hDEADBEEF);
        do_op(K_SW, 32'h104, 32'h0000CAFE, 0, -1, 32'h0, 32'h0);
        do_op(K_LL, 32'h200, 32'h0, 1, -1, 32'h0, 32'h11111111);
        do_op(K_SC, 32'h200, 32'd5, 0, -1, 32'h0, 32'h0);
        do_op(K_SC, 32'h200, 32'd5, 0, -1, 32'h0, 32'h0);
        do_op(K_LL, 32'h200, 32'h0, 0, -1, 32'h0, 32'h22222222);
        do_idle(1, 1'b1, 32'h203);
        do_op(K_SC, 32'h200, 32'd7, 2, -1, 32'h0, 32'h0);
        do_op(K_LL, 32'h200, 32'h0, 0, -1, 32'h0, 32'h33333333);
        do_op(K_SC, 32'h200, 32'd9, 3, 0, 32'h200, 32'h0);

        // Reset pulsed while an LL waits in WAIT with a live link.
        do_op(K_LL, 32'h200, 32'h0, 0, -1, 32'h0, 32'h12345678);
        req_ren   = 1'b1;
        req_ll    = 1'b1;
        req_addr  = 32'h200;
        dhit      = 1'b0;
        inv_valid = 1'b0;
        step();
        step();
        nRST = 1'b0;
        clear_req();
        probe(32'h0, 1'b0, 1'b0, 1'b0);
        step();
        nRST = 1'b1;
        m_lv = 1'b0;
        m_la = 32'h0;
        m_wb = 32'h0;
        do_op(K_SC, 32'h200, 32'd1, 0, -1, 32'h0, 32'h0);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            kind = int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 3));
            if ((kind == K_SC) && ($urandom_range(0, 1) == 1)) begin
                addr = {m_la[31:2], 2'($urandom_range(0, 3))};
            end else begin
                addr = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) begin
                ic = -1;
            end else begin
                ic = int'($urandom_range(0, n + 1));
            end
            if ($urandom_range(0, 1) == 1) begin
                ia = {m_la[31:2], 2'($urandom_range(0, 3))};
            end else begin
                ia = bases[$urandom_range(0, 3)];
            end
            do_op(kind, addr, $urandom, n, ic, ia, $urandom);
            if ($urandom_range(0, 2) != 0) begin
                do_idle(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)),
                        {m_la[31:2], 2'($urandom_range(0, 3))});
            end
        end

        do_idle(3, 1'b0, 32'h0);
        final_on = 1'b1;
        @(negedge CLK);
        #1;
        final_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
